// File: rtl/sfi_check_fifo_if.sv
// Handshake bundle between the SFI rewriter, the check FIFO and the consumer.
// slave is the FIFO's view; master is the view of the environment around it.
interface sfi_check_fifo_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_viol;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_viol
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_viol
  );
endinterface

// File: rtl/sfi_check_fifo.sv
// Show-ahead FIFO behind the SFI store-address rewriter. Every accepted word
// is audited: store-class opcodes without the sandbox tag in [63:56] are
// flagged alongside the word, counted (saturating) and latched as a sticky error.
module sfi_check_fifo #(
  parameter int         DEPTH       = 4,
  parameter logic [7:0] SANDBOX_TAG = 8'hA2,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sfi_check_fifo_if.slave  bus,
  input  logic             clr_err,
  output logic [CNT_W-1:0] viol_count,
  output logic             sticky_err
);
  localparam int AW = $clog2(DEPTH);

  // Each entry carries the violation flag in bit 64 next to the untouched word.
  logic [64:0]      mem_q [DEPTH];
  logic [64:0]      mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;

  logic       full, empty, in_ready, push, pop;
  logic       store_class, viol;
  logic [5:0] opc;

  // Status and handshakes; in_ready looks only at occupancy and reset.
  always_comb begin
    full     = (occ_q == (AW+1)'(DEPTH));
    empty    = (occ_q == '0);
    in_ready = rst_n & ~full;
    push     = bus.in_valid & in_ready;
    pop      = ~empty & bus.out_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = mem_q[rd_ptr_q][63:0];
  assign bus.out_viol  = ~empty & mem_q[rd_ptr_q][64];
  assign viol_count    = cnt_q;
  assign sticky_err    = sticky_q;

  // Classify the incoming word: untagged store-class opcodes are violations.
  always_comb begin
    opc = bus.in_data[31:26];
    case (opc)
      6'd40, 6'd41, 6'd42, 6'd43, 6'd44,
      6'd45, 6'd46, 6'd56, 6'd60, 6'd63: store_class = 1'b1;
      default:                           store_class = 1'b0;
    endcase
    viol = store_class & (bus.in_data[63:56] != SANDBOX_TAG);
  end

  // Next-state for storage, pointers, occupancy and the audit counters.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;

    if (push) begin
      mem_d[wr_ptr_q] = {viol, bus.in_data};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase

    // A violation in the same cycle as a clear wins, so it is never lost.
    if (push && viol) begin
      sticky_d = 1'b1;
      if (clr_err) begin
        cnt_d = CNT_W'(1);
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (clr_err) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  // Entry storage needs no reset; occupancy gates everything read from it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule
